// File: rtl/stream_arb_pkg.sv
// Shared FSM state type and round-robin search helper for the stream packet arbiter.
// Latency: none (declarations and a pure combinational function only).
// Backpressure: not applicable; holds no flow-control state.
package stream_arb_pkg;

    // Upper bound on the source count, so the search helper can use fixed widths
    localparam int MAX_SRC  = 16;
    localparam int MAX_ID_W = 4;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Returns {found, index} of the first set bit of req searching upward from
    // (last + 1) mod n with wrap-around. Bits at or above n are never selected.
    function automatic logic [MAX_ID_W:0] rr_first(
        input logic [MAX_SRC-1:0]  req,
        input logic [MAX_ID_W-1:0] last,
        input int                  n
    );
        logic [MAX_ID_W:0] res;
        int                idx;
        res = '0;
        for (int k = 1; k <= MAX_SRC; k++) begin
            idx = (int'(last) + k) % n;
            if ((k <= n) && !res[MAX_ID_W] && req[idx[MAX_ID_W-1:0]]) begin
                res = {1'b1, idx[MAX_ID_W-1:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/stream_rr_pick.sv
// Round-robin next-grant search: first requester after last_grant, with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is registered.
module stream_rr_pick
    import stream_arb_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0]         req,
    input  logic [$clog2(N_SRC)-1:0] last_grant,
    output logic [N_SRC-1:0]         pick_oh,
    output logic [$clog2(N_SRC)-1:0] pick_idx,
    output logic                     pick_vld
);

    localparam int ID_W = $clog2(N_SRC);

    logic [MAX_SRC-1:0]  req_pad;
    logic [MAX_ID_W-1:0] last_pad;
    logic [MAX_ID_W:0]   res;

    // Widen inputs to the helper's fixed widths, then decode its result
    always_comb begin
        req_pad              = '0;
        req_pad[N_SRC-1:0]   = req;
        last_pad             = '0;
        last_pad[ID_W-1:0]   = last_grant;
        res                  = rr_first(req_pad, last_pad, N_SRC);
        pick_vld             = res[MAX_ID_W];
        pick_idx             = ID_W'(res[MAX_ID_W-1:0]);
        pick_oh              = '0;
        if (res[MAX_ID_W]) begin
            pick_oh[pick_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/stream_pkt_arbiter.sv
// Packet-granular round-robin arbiter of N_SRC streams onto one registered output; optional watchdog under STREAM_ARB_WATCHDOG_EN.
// Latency: one cycle arbitration bubble per packet, then one registered cycle from accepted input beat to m_valid_o.
// Backpressure: only the granted source sees ready, equal to (~m_valid_o | m_ready_i); output holds stable while stalled.
module stream_pkt_arbiter
    import stream_arb_pkg::*;
#(
    parameter int T_DATA_WIDTH = 4,
    parameter int N_SRC        = 4,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_SRC-1:0][T_DATA_WIDTH-1:0]  s_data_i,
    input  logic [N_SRC-1:0]                    s_last_i,
    input  logic [N_SRC-1:0]                    s_valid_i,
    output logic [N_SRC-1:0]                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0]             m_data_o,
    output logic                                m_last_o,
    output logic                                m_valid_o,
    input  logic                                m_ready_i,
    output logic [$clog2(N_SRC)-1:0]            m_id_o,
    output logic                                err_timeout_o
);

    localparam int ID_W = $clog2(N_SRC);

    arb_state_t       state;
    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  last_grant;
    logic [N_SRC-1:0] grant_oh;
    logic [N_SRC-1:0] pick_oh;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_vld;
    logic             out_free;
    logic             beat_acc;

    stream_rr_pick #(
        .N_SRC (N_SRC)
    ) u_pick (
        .req        (s_valid_i),
        .last_grant (last_grant),
        .pick_oh    (pick_oh),
        .pick_idx   (pick_idx),
        .pick_vld   (pick_vld)
    );

    // Output slot takes a beat when empty or draining; only the granted source sees ready
    always_comb begin
        out_free  = ~m_valid_o | m_ready_i;
        s_ready_o = '0;
        if (state == ARB_BUSY) begin
            s_ready_o = grant_oh & {N_SRC{out_free}};
        end
        beat_acc  = |(s_ready_o & s_valid_i);
    end

`ifdef STREAM_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;
`else
    assign err_timeout_o = 1'b0;
`endif

    // Arbitration FSM, output register and (optionally) the stalled-source watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            grant_oh   <= '0;
            last_grant <= ID_W'(N_SRC - 1);
            m_valid_o  <= 1'b0;
            m_last_o   <= 1'b0;
            m_data_o   <= '0;
            m_id_o     <= '0;
`ifdef STREAM_ARB_WATCHDOG_EN
            err_timeout_o <= 1'b0;
            wd_cnt        <= '0;
`endif
        end else begin
`ifdef STREAM_ARB_WATCHDOG_EN
            err_timeout_o <= 1'b0;
`endif
            if (beat_acc) begin
                m_valid_o <= 1'b1;
                m_data_o  <= s_data_i[grant];
                m_last_o  <= s_last_i[grant];
                m_id_o    <= grant;
            end else if (m_ready_i) begin
                m_valid_o <= 1'b0;
            end

            case (state)
                ARB_IDLE: begin
                    if (pick_vld) begin
                        state    <= ARB_BUSY;
                        grant    <= pick_idx;
                        grant_oh <= pick_oh;
                    end
                end
                ARB_BUSY: begin
                    if (beat_acc && s_last_i[grant]) begin
                        state      <= ARB_IDLE;
                        last_grant <= grant;
                    end
`ifdef STREAM_ARB_WATCHDOG_EN
                    if (beat_acc) begin
                        wd_cnt <= '0;
                    end else if (!s_valid_i[grant]) begin
                        if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
                            err_timeout_o <= 1'b1;
                            state         <= ARB_IDLE;
                            last_grant    <= grant;
                            wd_cnt        <= '0;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end
`endif
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_pkt_arbiter.sv
// Directed bench for stream_pkt_arbiter (N_SRC=4, 4-bit data, TIMEOUT_CYC=8).
// Sources are per-index beat queues advanced on handshake; accepted output beats are logged and compared.
// Watchdog-specific expectations follow STREAM_ARB_WATCHDOG_EN.
module tb_stream_pkt_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0][W-1:0] s_data_i;
    logic [N-1:0]        s_last_i;
    logic [N-1:0]        s_valid_i;
    logic [N-1:0]        s_ready_o;
    logic [W-1:0]        m_data_o;
    logic                m_last_o;
    logic                m_valid_o;
    logic                m_ready_i;
    logic [1:0]          m_id_o;
    logic                err_timeout_o;

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [4:0] sq [0:N-1][0:31];
    int         sq_wr [0:N-1];
    int         sq_rd [0:N-1];
    logic [N-1:0] src_en;
    logic [6:0] olog [0:31];
    int         ocyc [0:31];
    int         n_out;
    logic [6:0] exp_c [0:11];

    always #5 clk = ~clk;

    stream_pkt_arbiter #(
        .T_DATA_WIDTH (W),
        .N_SRC        (N),
        .TIMEOUT_CYC  (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_data_i      (s_data_i),
        .s_last_i      (s_last_i),
        .s_valid_i     (s_valid_i),
        .s_ready_o     (s_ready_o),
        .m_data_o      (m_data_o),
        .m_last_o      (m_last_o),
        .m_valid_o     (m_valid_o),
        .m_ready_i     (m_ready_i),
        .m_id_o        (m_id_o),
        .err_timeout_o (err_timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] bt(input logic [1:0] id, input logic l, input logic [3:0] d);
        return {id, l, d};
    endfunction

    task automatic push(input int src, input logic l, input logic [3:0] d);
        sq[src][sq_wr[src]] = {l, d};
        sq_wr[src]++;
    endtask

    // Non-presented sources drive junk data with last=1, which must be ignored
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_en[i] && (sq_rd[i] < sq_wr[i])) begin
                s_valid_i[i] = 1'b1;
                s_last_i[i]  = sq[i][sq_rd[i]][4];
                s_data_i[i]  = sq[i][sq_rd[i]][3:0];
            end else begin
                s_valid_i[i] = 1'b0;
                s_last_i[i]  = 1'b1;
                s_data_i[i]  = 4'hF;
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0] hs;
        logic         o_hs;
        logic         stall;
        logic         rst_s;
        logic [6:0]   prev;
        #2;
        hs    = s_valid_i & s_ready_o;
        o_hs  = m_valid_o & m_ready_i;
        stall = m_valid_o & ~m_ready_i;
        rst_s = rst;
        prev  = {m_id_o, m_last_o, m_data_o};
        @(posedge clk);
        #1;
        cyc++;
        if (o_hs === 1'b1 && n_out < 32) begin
            olog[n_out] = prev;
            ocyc[n_out] = cyc;
            n_out++;
        end
        for (int i = 0; i < N; i++) begin
            if (hs[i] === 1'b1) sq_rd[i]++;
        end
        if (stall === 1'b1 && rst_s === 1'b0) begin
            chk("stall_hold", {25'd0, m_id_o, m_last_o, m_data_o}, {25'd0, prev});
        end
        drive();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_log(input string tag, input int i, input logic [6:0] e);
        chk($sformatf("%s_log%0d", tag, i), {25'd0, olog[i]}, {25'd0, e});
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            sq_wr[i] = 0;
            sq_rd[i] = 0;
        end
        src_en    = '1;
        n_out     = 0;
        rst       = 1'b1;
        m_ready_i = 1'b1;
        drive();
        ticks(3);

        // Reset state, with requests already pending (ignored while in reset)
        push(0, 1'b1, 4'hA); push(0, 1'b1, 4'hB);
        push(1, 1'b1, 4'h1); push(2, 1'b1, 4'h2); push(3, 1'b1, 4'h3);
        drive();
        tick();
        chk("rst_m_valid", m_valid_o, 1'b0);
        chk("rst_m_last",  m_last_o, 1'b0);
        chk("rst_m_data",  m_data_o, 4'h0);
        chk("rst_m_id",    m_id_o, 2'd0);
        chk("rst_err",     err_timeout_o, 1'b0);
        chk("rst_s_ready", s_ready_o, 4'b0000);

        // All four request: grant order 0,1,2,3,0
        rst = 1'b0;
        n_out = 0;
        ticks(12);
        chk("B_count", n_out, 5);
        chk_log("B", 0, bt(2'd0, 1'b1, 4'hA));
        chk_log("B", 1, bt(2'd1, 1'b1, 4'h1));
        chk_log("B", 2, bt(2'd2, 1'b1, 4'h2));
        chk_log("B", 3, bt(2'd3, 1'b1, 4'h3));
        chk_log("B", 4, bt(2'd0, 1'b1, 4'hB));
        chk("B_gap", ocyc[1] - ocyc[0], 2);

        // Sources 0 and 2 with back-to-back 3-beat packets alternate after a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_out = 0;
        push(0, 1'b0, 4'h1); push(0, 1'b0, 4'h2); push(0, 1'b1, 4'h3);
        push(0, 1'b0, 4'h4); push(0, 1'b0, 4'h5); push(0, 1'b1, 4'h6);
        push(2, 1'b0, 4'h7); push(2, 1'b0, 4'h8); push(2, 1'b1, 4'h9);
        push(2, 1'b0, 4'hA); push(2, 1'b0, 4'hB); push(2, 1'b1, 4'hC);
        exp_c = '{bt(0, 0, 4'h1), bt(0, 0, 4'h2), bt(0, 1, 4'h3),
                  bt(2, 0, 4'h7), bt(2, 0, 4'h8), bt(2, 1, 4'h9),
                  bt(0, 0, 4'h4), bt(0, 0, 4'h5), bt(0, 1, 4'h6),
                  bt(2, 0, 4'hA), bt(2, 0, 4'hB), bt(2, 1, 4'hC)};
        drive();
        ticks(20);
        chk("C_count", n_out, 12);
        for (int i = 0; i < 12; i++) chk_log("C", i, exp_c[i]);
        chk("C_back2back", ocyc[1] - ocyc[0], 1);
        chk("C_bubble", ocyc[3] - ocyc[2], 2);

        // Downstream ready toggling mid-packet: no loss, duplication or change while stalled
        n_out = 0;
        push(1, 1'b0, 4'h1); push(1, 1'b0, 4'h2); push(1, 1'b0, 4'h3); push(1, 1'b1, 4'h4);
        drive();
        ticks(2);
        for (int i = 0; i < 10; i++) begin
            m_ready_i = i[0];
            tick();
        end
        m_ready_i = 1'b1;
        tick();
        chk("D_count", n_out, 4);
        chk_log("D", 0, bt(2'd1, 1'b0, 4'h1));
        chk_log("D", 1, bt(2'd1, 1'b0, 4'h2));
        chk_log("D", 2, bt(2'd1, 1'b0, 4'h3));
        chk_log("D", 3, bt(2'd1, 1'b1, 4'h4));

        // Single-beat packets from source 3 alone win consecutively
        n_out = 0;
        push(3, 1'b1, 4'hC); push(3, 1'b1, 4'hD); push(3, 1'b1, 4'hE);
        drive();
        ticks(9);
        chk("E_count", n_out, 3);
        chk_log("E", 0, bt(2'd3, 1'b1, 4'hC));
        chk_log("E", 1, bt(2'd3, 1'b1, 4'hD));
        chk_log("E", 2, bt(2'd3, 1'b1, 4'hE));
        chk("E_gap", ocyc[2] - ocyc[1], 2);

        // Reset during beat 2 of a 4-beat packet, then fresh arbitration from index 0
        n_out = 0;
        push(1, 1'b0, 4'h5); push(1, 1'b0, 4'h6); push(1, 1'b0, 4'h7); push(1, 1'b1, 4'h8);
        drive();
        ticks(2);
        rst = 1'b1;
        tick();
        chk("F_rst_m_valid", m_valid_o, 1'b0);
        chk("F_rst_m_last",  m_last_o, 1'b0);
        chk("F_rst_m_data",  m_data_o, 4'h0);
        chk("F_rst_m_id",    m_id_o, 2'd0);
        chk("F_rst_s_ready", s_ready_o, 4'b0000);
        chk("F_pre_count", n_out, 1);
        chk_log("F", 0, bt(2'd1, 1'b0, 4'h5));
        rst = 1'b0;
        sq_rd[1] = sq_wr[1];
        n_out = 0;
        push(0, 1'b1, 4'h9); push(1, 1'b1, 4'hA);
        drive();
        ticks(6);
        chk("F_post_count", n_out, 2);
        chk_log("Fpost", 0, bt(2'd0, 1'b1, 4'h9));
        chk_log("Fpost", 1, bt(2'd1, 1'b1, 4'hA));

        // Granted source 1 drops valid mid-packet while source 2 waits
        n_out = 0;
        push(1, 1'b0, 4'h1); push(1, 1'b0, 4'h2); push(1, 1'b1, 4'h3);
        drive();
        ticks(2);
        src_en[1] = 1'b0;
        push(2, 1'b1, 4'h4);
        drive();
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("G_err_quiet%0d", i), err_timeout_o, 1'b0);
        end
        tick();
`ifdef STREAM_ARB_WATCHDOG_EN
        chk("G_err_pulse", err_timeout_o, 1'b1);
        tick();
        chk("G_err_clear", err_timeout_o, 1'b0);
        chk("G_regrant", s_ready_o, 4'b0100);
        sq_rd[1] = sq_wr[1];
        src_en[1] = 1'b1;
        drive();
        ticks(6);
        chk("G_count", n_out, 2);
        chk_log("G", 0, bt(2'd1, 1'b0, 4'h1));
        chk_log("G", 1, bt(2'd2, 1'b1, 4'h4));
`else
        chk("G_no_err", err_timeout_o, 1'b0);
        tick();
        chk("G_no_err2", err_timeout_o, 1'b0);
        chk("G_grant_held", s_ready_o, 4'b0010);
        src_en[1] = 1'b1;
        drive();
        ticks(8);
        chk("G_count", n_out, 4);
        chk_log("G", 0, bt(2'd1, 1'b0, 4'h1));
        chk_log("G", 1, bt(2'd1, 1'b0, 4'h2));
        chk_log("G", 2, bt(2'd1, 1'b1, 4'h3));
        chk_log("G", 3, bt(2'd2, 1'b1, 4'h4));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
